// File: rtl/msg_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : msg_uart_tx
// Purpose  : Sends a short message from a character ROM over 8N1 UART.
//            Characters are read one per frame starting at address 0; the
//            message ends after MSG_LEN characters or at the first NUL byte.
// Revision : 1.0 - initial release
// ============================================================================
module msg_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MSG_LEN      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] addr,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int                 CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]         ADDR_LAST = 4'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] cyc_cnt_nx;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_cnt_nx;
  logic [7:0]       shreg;
  logic [7:0]       shreg_nx;
  logic [3:0]       addr_nx;
  logic             tx_nx;
  logic             done_nx;
  logic             bit_end;

  assign bit_end = (cyc_cnt == CNT_LAST);
  assign busy    = (state != S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and next-datapath values; the counter restarts on every state change
  always_comb begin
    state_nx   = state;
    cyc_cnt_nx = cyc_cnt + 1'b1;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    addr_nx    = addr;
    done_nx    = 1'b0;
    case (state)
      S_IDLE: begin
        cyc_cnt_nx = '0;
        bit_cnt_nx = 3'd0;
        if (start) begin
          state_nx = S_FETCH;
          addr_nx  = 4'd0;
        end
      end
      S_FETCH: begin
        cyc_cnt_nx = '0;
        bit_cnt_nx = 3'd0;
        if (data == 8'h00) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
          addr_nx  = 4'd0;
        end else begin
          shreg_nx = data;
          state_nx = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nx   = S_DATA;
          cyc_cnt_nx = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cyc_cnt_nx = '0;
          bit_cnt_nx = bit_cnt + 3'd1;
          shreg_nx   = {1'b0, shreg[7:1]};
          if (bit_cnt == 3'd7) begin
            state_nx = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cyc_cnt_nx = '0;
          if (addr == ADDR_LAST) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
            addr_nx  = 4'd0;
          end else begin
            state_nx = S_FETCH;
            addr_nx  = addr + 4'd1;
          end
        end
      end
      default: begin
        state_nx   = S_IDLE;
        cyc_cnt_nx = '0;
        bit_cnt_nx = 3'd0;
        addr_nx    = 4'd0;
      end
    endcase

    // tx is registered from the upcoming state so the line changes cleanly on the clock
    case (state_nx)
      S_START: tx_nx = 1'b0;
      S_DATA:  tx_nx = shreg_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

  // Datapath registers: counters, shift register, address, line and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      addr    <= 4'd0;
      tx      <= 1'b1;
      done    <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      addr    <= addr_nx;
      tx      <= tx_nx;
      done    <= done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msg_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_msg_uart_tx
// Purpose  : Directed self-checking bench for msg_uart_tx (CLKS_PER_BIT=4),
//            with one instance at MSG_LEN=8 and one at MSG_LEN=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msg_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] addr8, addr16;
  logic [7:0] data8, data16;
  logic       tx8, tx16, busy8, busy16, done8, done16;

  int rom_mode = 0;
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int d8n = 0, d8c = 0, d16n = 0, d16c = 0, amax = 0, t16low = 0;
  int base;
  logic [9:0] fr;
  logic       first;

  logic [7:0] exp_msg [8] = '{8'h53, 8'h54, 8'h55, 8'h44, 8'h45, 8'h4E, 8'h54, 8'h20};

  msg_uart_tx #(.CLKS_PER_BIT(4), .MSG_LEN(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .addr(addr8), .data(data8),
    .tx(tx8), .busy(busy8), .done(done8)
  );

  msg_uart_tx #(.CLKS_PER_BIT(4), .MSG_LEN(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .addr(addr16), .data(data16),
    .tx(tx16), .busy(busy16), .done(done16)
  );

  always #5 clk = ~clk;

  // "STUDENT " at 0..7, NUL elsewhere; mode 1 is an all-NUL ROM
  function automatic logic [7:0] rom(input logic [3:0] a, input int mode);
    if (mode != 0) return 8'h00;
    case (a)
      4'd0: return 8'h53;
      4'd1: return 8'h54;
      4'd2: return 8'h55;
      4'd3: return 8'h44;
      4'd4: return 8'h45;
      4'd5: return 8'h4E;
      4'd6: return 8'h54;
      4'd7: return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  // Combinational character ROMs
  always_comb begin
    data8  = rom(addr8, rom_mode);
    data16 = rom(addr16, rom_mode);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done8)  begin d8n++;  d8c = cyc;  end
    if (done16) begin d16n++; d16c = cyc; end
    if (int'(addr16) > amax) amax = int'(addr16);
    if (tx16 == 1'b0) t16low++;
  endtask

  // Entered in a FETCH cycle; leaves 41 cycles later. Bit samples taken mid-bit.
  task automatic run_char(input int pulse_at, input logic hold,
                          output logic [9:0] f, output logic ftx);
    f   = '0;
    ftx = 1'b1;
    for (int i = 0; i < 41; i++) begin
      start = hold || (i == pulse_at);
      tick();
      if (i == 0) ftx = tx8;
      if (i < 40 && (i % 4) == 1) f[i/4] = tx8;
    end
  endtask

  initial begin
    // ---------------- reset with start held high ----------------
    rst = 1'b1; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_tx",   tx8,   1'b1);
      check("rst_busy", busy8, 1'b0);
      check("rst_done", done8, 1'b0);
      check("rst_addr", addr8, 4'd0);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    check("post_rst_tx",   tx8,   1'b1);
    check("post_rst_busy", busy8, 1'b0);
    check("post_rst_done", done8, 1'b0);
    check("post_rst_addr", addr8, 4'd0);

    // ---------------- full message, both MSG_LEN variants ----------------
    d8n = 0; d16n = 0; amax = 0; t16low = 0;
    base = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fetch0_addr", addr8, 4'd0);
    check("fetch0_busy", busy8, 1'b1);
    check("fetch0_tx",   tx8,   1'b1);
    for (int k = 0; k < 8; k++) begin
      run_char(-1, 1'b0, fr, first);
      if (k == 0) check("first_tx_low", first, 1'b0);
      check($sformatf("frame%0d", k), fr, {1'b1, exp_msg[k], 1'b0});
    end
    check("done8_now",   done8, 1'b1);
    check("done8_busy",  busy8, 1'b0);
    check("done8_count", d8n, 1);
    check("done8_cycle", d8c - base, 329);
    check("nul_addr16",  addr16, 4'd8);
    check("nul_busy16",  busy16, 1'b1);
    check("nul_done16",  done16, 1'b0);
    tick();
    check("done16_now",  done16, 1'b1);
    check("done16_busy", busy16, 1'b0);
    check("done8_gone",  done8, 1'b0);
    t16low = 0;
    for (int i = 0; i < 50; i++) tick();
    check("no_ninth_frame", t16low, 0);
    check("done16_count",   d16n, 1);
    check("addr16_max",     amax, 8);

    // ---------------- empty message ----------------
    rom_mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_busy_n1", busy8, 1'b1);
    check("empty_done_n1", done8, 1'b0);
    check("empty_tx_n1",   tx8,   1'b1);
    tick();
    check("empty_done_n2", done8, 1'b1);
    check("empty_busy_n2", busy8, 1'b0);
    check("empty_tx_n2",   tx8,   1'b1);
    tick();
    check("empty_done_n3", done8, 1'b0);
    rom_mode = 0;

    // ---------------- reset during third data bit of 'T' ----------------
    start = 1'b1;
    tick();
    start = 1'b0;
    run_char(-1, 1'b0, fr, first);
    check("mid_frame_S", fr, {1'b1, 8'h53, 1'b0});
    for (int i = 0; i < 14; i++) tick();
    check("mid_pos_addr", addr8, 4'd1);
    check("mid_pos_tx",   tx8,   1'b1);
    d8n = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_tx",   tx8,   1'b1);
    check("abort_busy", busy8, 1'b0);
    check("abort_addr", addr8, 4'd0);
    check("abort_done", done8, 1'b0);
    for (int i = 0; i < 45; i++) tick();
    check("abort_no_done", d8n, 0);
    check("abort_idle_tx", tx8, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_addr", addr8, 4'd0);
    run_char(-1, 1'b0, fr, first);
    check("restart_S", fr, {1'b1, 8'h53, 1'b0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // ---------------- start while busy, then start held ----------------
    d8n = 0;
    base = cyc;
    start = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      run_char((k == 1 || k == 4) ? 10 : -1, (k >= 6), fr, first);
      check($sformatf("busy_frame%0d", k), fr, {1'b1, exp_msg[k], 1'b0});
    end
    check("held_done",       done8, 1'b1);
    check("held_done_count", d8n, 1);
    check("held_done_cycle", d8c - base, 329);
    tick();
    start = 1'b0;
    check("held_fetch_busy", busy8, 1'b1);
    check("held_fetch_addr", addr8, 4'd0);
    check("held_fetch_done", done8, 1'b0);
    run_char(-1, 1'b0, fr, first);
    check("held_frame_S", fr, {1'b1, 8'h53, 1'b0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msg_uart_tx.md
MSG_UART_TX -- requirements
Module: msg_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200), legal range >= 2.
REQ-002 SHALL have parameter MSG_LEN, default 8, maximum characters per message, legal range 1..16.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port start, input, 1, level-sampled request to send the message.
REQ-006 SHALL have port addr, output, 4, character ROM address.
REQ-007 SHALL have port data, input, 8, ASCII byte returned combinationally by the character ROM for addr.
REQ-008 SHALL have port tx, output, 1, UART serial line, idle high, registered.
REQ-009 SHALL have port busy, output, 1, high whenever a message is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at message end.

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, START, DATA, STOP.
REQ-012 IDLE: tx=1, busy=0; start=1 sampled -> FETCH with addr=0.
REQ-013 FETCH (exactly 1 cycle): addr held stable; end of cycle, data==8'h00 -> IDLE with done pulse (no frame sent); else data loaded into an 8-bit shift register -> START.
REQ-014 START: tx=0 for CLKS_PER_BIT cycles -> DATA.
REQ-015 DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles -> STOP.
REQ-016 STOP: tx=1 for CLKS_PER_BIT cycles; then addr==MSG_LEN-1 -> IDLE with done pulse; else addr+1 -> FETCH.
REQ-017 Per-character cost SHALL be exactly 1 + 10*CLKS_PER_BIT cycles.
REQ-018 Latency: start sampled in cycle N -> addr=0 in N+1 -> tx=0 first in cycle N+2.
REQ-019 addr SHALL never wrap: with MSG_LEN=16, message ends after addr 15.
REQ-020 done SHALL be high exactly one cycle, the first cycle busy is low again; busy SHALL be high in every non-IDLE cycle.
REQ-021 start SHALL be ignored outside IDLE; start held high SHALL restart the message from addr 0 the cycle after done.
REQ-022 tx SHALL contain no glitches; bit-period counter SHALL reset on every state change.
REQ-023 data SHALL be sampled only in FETCH; changes on data in other states SHALL have no effect.

Reset
REQ-024 rst=1 at a clock edge SHALL force: state=IDLE, tx=1, busy=0, done=0, addr=0, shift register=0, bit and cycle counters=0.
REQ-025 rst SHALL take priority over start and over all in-progress activity, including mid-frame; no done pulse SHALL result from an aborted message.

Verification (CLKS_PER_BIT=4, character ROM holding "STUDENT " at addr 0..7, 8'h00 elsewhere)
REQ-026 Reset: rst high 2 cycles, start=1 -> tx=1, busy=0, done=0, addr=0 throughout and on the cycle after release with start=0.
REQ-027 Full message, MSG_LEN=8: start pulse in cycle N -> tx low at N+2; first frame 0,1,1,0,0,1,0,1,0,1 (0x53 'S'); 8 frames decode "STUDENT "; done=1 only in cycle N+329.
REQ-028 NUL termination, MSG_LEN=16: same stimulus -> 8 frames, FETCH at addr 8 reads 8'h00, done in the cycle after that FETCH, no ninth frame, addr never exceeds 8.
REQ-029 Empty message: ROM returns 8'h00 at addr 0 -> tx stays 1, done=1 in cycle N+2, busy high only in N+1.
REQ-030 Mid-frame reset: rst asserted during third data bit of 'T' -> next cycle tx=1, busy=0, addr=0, no done pulse; subsequent start sends the message from 'S'.
REQ-031 Start while busy: start pulses during frames 2 and 5 ignored; start held high -> second message FETCH addr=0 in the cycle after done.
